mips_run_ctrl: RTL

Run/load sequencer for the single-cycle MIPS core. It streams a program into instruction memory over a valid/ready port, then holds the core in reset for a fixed window and releases it. It lets the core run until a halt word is fetched or a cycle budget expires, then freezes the core so registers and data memory can be inspected. It sits between the bench or host and the core's reset, stall and imem write ports.

---
 rtl/mips_ctrl_pkg.sv | 17 +
 rtl/mips_run_ctrl_run_budget_counter.sv | 46 ++++
 rtl/mips_run_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS run/load sequencer: controller states and
// default values for the halt encoding, reset-hold window and counter width.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } run_state_t;

  localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;
  localparam int          RESET_HOLD_DEF = 2;
  localparam int          CNT_W_DEF      = 16;

endpackage

// File: rtl/mips_run_ctrl_run_budget_counter.sv
// Saturating retired-instruction counter. 'expire' flags the cycle in which
// the next increment would reach a non-zero budget, so the controller can
// stop the core on exactly that instruction.
module run_budget_counter
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] budget,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W:0]   count_inc_s;

  // One extra bit so the all-ones count does not wrap when compared to budget.
  assign count_inc_s = {1'b0, count_r} + {{CNT_W{1'b0}}, 1'b1};
  assign count       = count_r;

  // Budget expiry: a zero budget means the run is unlimited.
  always_comb begin
    expire = 1'b0;
    if ((budget != {CNT_W{1'b0}}) && (count_inc_s == {1'b0, budget})) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

  // Counter register: clear wins over enable, and the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_inc_s[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/load sequencer for the single-cycle MIPS core: streams a program into
// imem, holds the core in reset for a fixed window, lets it run until a halt
// word is fetched or the cycle budget is used up, then freezes it.
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEF,
  parameter int          RESET_HOLD = RESET_HOLD_DEF,
  parameter int          CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_valid,
  input  logic [31:0]       prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              core_stall,
  input  logic [31:0]       core_instr,
  input  logic [CNT_W-1:0]  cycle_budget,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              err_overflow,
  output logic [ADDR_W:0]   load_count,
  output logic [CNT_W-1:0]  cycles
);

  localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  run_state_t        state_r, state_nxt_s;
  logic [ADDR_W:0]   load_count_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              busy_r, done_r, timeout_r, err_overflow_r;
  logic              accept_s, clear_s, cnt_en_s, expire_s;
  logic              set_timeout_s, set_ovf_s, hold_inc_s;
  logic              prog_ready_s, core_reset_s, core_stall_s;

  // A word is taken only while loading; valid elsewhere is ignored.
  assign accept_s   = prog_valid && (state_r == ST_LOAD);
  assign imem_we    = accept_s;
  assign imem_waddr = load_count_r[ADDR_W-1:0];
  assign imem_wdata = prog_data;

  assign prog_ready   = prog_ready_s;
  assign core_reset   = core_reset_s;
  assign core_stall   = core_stall_s;
  assign busy         = busy_r;
  assign done         = done_r;
  assign timeout      = timeout_r;
  assign err_overflow = err_overflow_r;
  assign load_count   = load_count_r;

  run_budget_counter #(.CNT_W(CNT_W)) u_budget (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_s),
    .enable (cnt_en_s),
    .budget (cycle_budget),
    .count  (cycles),
    .expire (expire_s)
  );

  // Next-state and core-control decode; halt is checked before the budget.
  always_comb begin
    state_nxt_s   = state_r;
    prog_ready_s  = 1'b0;
    core_reset_s  = 1'b1;
    core_stall_s  = 1'b1;
    clear_s       = 1'b0;
    cnt_en_s      = 1'b0;
    set_timeout_s = 1'b0;
    set_ovf_s     = 1'b0;
    hold_inc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          clear_s     = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        prog_ready_s = 1'b1;
        if (accept_s && prog_last) begin
          state_nxt_s = ST_HOLD;
        end else if (accept_s && (load_count_r[ADDR_W-1:0] == ADDR_LAST)) begin
          set_ovf_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          hold_inc_s  = 1'b1;
          state_nxt_s = ST_HOLD;
        end
      end
      ST_RUN: begin
        core_reset_s = 1'b0;
        if (core_instr == HALT_WORD) begin
          state_nxt_s = ST_DONE;
        end else begin
          core_stall_s = 1'b0;
          cnt_en_s     = 1'b1;
          if (expire_s) begin
            set_timeout_s = 1'b1;
            state_nxt_s   = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        core_reset_s = 1'b0;
        if (start) begin
          clear_s     = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, status flags and load/hold counters; busy/done decode the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      load_count_r   <= {(ADDR_W+1){1'b0}};
      hold_cnt_r     <= {HOLD_W{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      timeout_r      <= 1'b0;
      err_overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_HOLD) ||
                    (state_nxt_s == ST_RUN);
      done_r     <= (state_nxt_s == ST_DONE);
      hold_cnt_r <= hold_inc_s ? (hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1}) : {HOLD_W{1'b0}};
      if (clear_s) begin
        load_count_r   <= {(ADDR_W+1){1'b0}};
        timeout_r      <= 1'b0;
        err_overflow_r <= 1'b0;
      end else begin
        if (accept_s) begin
          load_count_r <= load_count_r + {{ADDR_W{1'b0}}, 1'b1};
        end
        if (set_timeout_s) begin
          timeout_r <= 1'b1;
        end
        if (set_ovf_s) begin
          err_overflow_r <= 1'b1;
        end
      end
    end
  end

endmodule
